mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port (DataMem-style: async read, write on clock edge, neg-asserted write enable) between two requesters: instruction fetch (IF) and load/store (D).
- Sits between the multi-cycle CPU front end and the memory. Arbitrates requests, latches the winning request, and holds the memory bus stable for LATENCY wait-state cycles.
- Returns read data with a one-cycle valid pulse.

Parameters:
- LATENCY, 2, number of memory access cycles per transaction (legal 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- if_req  input  1  fetch request (level).
- if_addr  input  32  fetch address (always a word read).
- if_gnt  output  1  fetch request accepted this cycle.
- if_valid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  32  fetch read data.
- d_req  input  1  data request (level).
- d_addr  input  32  data address.
- d_size  input  2  00 byte, 01 halfword, 10 word.
- d_we  input  1  1 = store, 0 = load.
- d_wdata  input  32  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_valid  output  1  one-cycle pulse: access complete (load or store).
- d_rdata  output  32  load data.
- mem_addr  output  32  memory address.
- mem_size  output  2  memory access size.
- mem_wdata  output  32  memory write data.
- mem_wen  output  1  memory write enable, active-low.
- mem_rdata  input  32  memory read data (combinational from mem_addr).

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, cnt=0, if_valid=d_valid=0, if_rdata=d_rdata=0, owner=IF, last-served=D.
  - mem_wen is forced 1 combinationally whenever rst=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - if_gnt and d_gnt are combinational. At most one is high, and only in IDLE with the matching req high and rst=1.
  - Arbitration: fixed priority, D wins over IF (see Optional Feature).
  - On the edge where a grant is high, latch addr/size/we/wdata and owner, load cnt=LATENCY-1, and go to ACCESS.
  - For an IF grant, latch size=10 and we=0.
- ACCESS:
  - mem_addr, mem_size and mem_wdata are driven from the latched registers.
  - Each edge: cnt decrements. When cnt=0, go to RESP.
  - mem_wen=0 only when cnt=0 and latched we=1, so each store writes exactly once.
  - On the edge leaving ACCESS, a read latches mem_rdata into the owner's rdata register. A store leaves d_rdata unchanged.
- RESP:
  - The owner's valid output is 1 for exactly this cycle.
  - No grant is issued in RESP; the next edge goes to IDLE.
- Timing: grant in cycle T, ACCESS in T+1..T+LATENCY, valid in T+LATENCY+1. Earliest next grant is T+LATENCY+2.
- Outside ACCESS: mem_addr, mem_size and mem_wdata hold their last latched values; mem_wen=1.
- Boundary conditions:
  - Dropping req after grant has no effect: the transaction completes and valid still pulses.
  - A req held high through RESP is re-arbitrated in the following IDLE cycle.
  - if_valid and d_valid are never high together.
  - Reset mid-ACCESS aborts the transaction: no write if cnt had not reached 0, no valid pulse.
  - LATENCY=1: a single ACCESS cycle, which also carries the write.
  - d_size=11 is passed through unchanged; the memory's behaviour for it is undefined.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both reqs are high in IDLE, grant the requester not in last-served, then update last-served to the granted one. A single requester is always granted. Reset value of last-served=D, so the first contended grant goes to IF.
- Undefined: fixed priority, D always wins. The last-served register is not built.

Test Plan:
- Reset then fetch. LATENCY=2, rst=0 for 2 cycles; then if_req=1, if_addr=0x0000_0010, mem returns 0x0020_8133 → if_gnt high in cycle T, if_valid=1 in T+3 with if_rdata=0x0020_8133, mem_wen=1 throughout.
- Store then load. d_req/d_we=1, d_addr=0x100, d_size=10, d_wdata=0xDEAD_BEEF → mem_wen=0 in exactly one cycle (T+2), d_valid in T+3. A following load of 0x100 returns d_rdata=0xDEAD_BEEF.
- Contention. if_req=d_req=1 held continuously:
  - without the macro → grants D,D,D every 4 cycles and IF never granted;
  - with ARB_ROUND_ROBIN_EN → grants IF,D,IF,D.
- Reset mid-access. Store to 0x200 with LATENCY=4, rst=0 during the 2nd ACCESS cycle → no mem_wen=0 pulse, no d_valid, state IDLE after the edge, memory at 0x200 unchanged.
- LATENCY=1 with request dropped. Load granted, then d_req=0 next cycle → d_valid in T+2 with correct data. Next grant is no earlier than T+3.
- Byte store. d_size=00, d_addr=0x103, d_wdata=0x0000_00AB → mem_size=00 and mem_addr=0x103 during the write cycle, read-back byte=0xAB.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch / load-store) arbiter for one shared memory port.
// Optional round-robin arbitration under ARB_ROUND_ROBIN_EN; default build is fixed priority with D first.
module mem_port_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_we;
    logic        owner_d;
    logic        last_cycle;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_d;
`endif

    assign last_cycle = (state == ACCESS) && (cnt == 4'd0);

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst && state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (if_req && d_req) begin
                if_gnt = last_d;
                d_gnt  = !last_d;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
`else
            d_gnt  = d_req;
            if_gnt = if_req && !d_req;
`endif
        end
    end

    always_comb begin
        state_next = state;
        if_valid   = 1'b0;
        d_valid    = 1'b0;
        case (state)
            IDLE:    if (if_gnt || d_gnt) state_next = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = RESP;
            RESP: begin
                state_next = IDLE;
                if_valid   = !owner_d;
                d_valid    = owner_d;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write strobe is confined to the final wait-state so a store hits memory exactly once.
    assign mem_wen   = !(rst && last_cycle && lat_we);
    assign mem_addr  = lat_addr;
    assign mem_size  = lat_size;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner_d   <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_size  <= 2'b00;
            lat_we    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (if_gnt || d_gnt) begin
                lat_addr  <= d_gnt ? d_addr : if_addr;
                lat_size  <= d_gnt ? d_size : 2'b10;
                lat_we    <= d_gnt && d_we;
                lat_wdata <= d_wdata;
                owner_d   <= d_gnt;
                cnt       <= 4'(LATENCY - 1);
`ifdef ARB_ROUND_ROBIN_EN
                last_d    <= d_gnt;
`endif
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (last_cycle && !lat_we) begin
                if (owner_d) d_rdata  <= mem_rdata;
                else         if_rdata <= mem_rdata;
            end
        end
    end

endmodule
